// File: rtl/mem_wb_stage_buf.sv
// Elastic MEM->WB stage: head entry plus an optional skid entry (`define MEM_WB_SKID_EN),
// writeback data selected at capture, forwarding tap and saturating back-pressure counter.
module mem_wb_stage_buf #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_regwrite,
    input  logic                  in_memtoreg,
    input  logic [REG_ADDR_W-1:0] in_writereg,
    input  logic [DATA_W-1:0]     in_aluresult,
    input  logic [DATA_W-1:0]     in_readdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_regwrite,
    output logic                  out_memtoreg,
    output logic [REG_ADDR_W-1:0] out_writereg,
    output logic [DATA_W-1:0]     out_wbdata,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_reg,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic                  regwrite;
        logic                  memtoreg;
        logic [REG_ADDR_W-1:0] writereg;
        logic [DATA_W-1:0]     wbdata;
    } entry_t;

    state_e           state_q;
    entry_t           head_q;
`ifdef MEM_WB_SKID_EN
    entry_t           skid_q;
`endif
    logic [CNT_W-1:0] stall_cnt_q;
    entry_t           in_entry_d;
    logic             push;
    logic             pop;

    // Writeback mux lives on the capture side so WB sees a plain register.
    always_comb begin
        in_entry_d          = '0;
        in_entry_d.regwrite = in_regwrite;
        in_entry_d.memtoreg = in_memtoreg;
        in_entry_d.writereg = in_writereg;
        in_entry_d.wbdata   = in_memtoreg ? in_readdata : in_aluresult;
    end

    assign out_valid = (state_q != ST_EMPTY);

`ifdef MEM_WB_SKID_EN
    assign in_ready = !reset && (state_q != ST_TWO);
`else
    assign in_ready = !reset && (!out_valid || out_ready);
`endif

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            head_q      <= '0;
`ifdef MEM_WB_SKID_EN
            skid_q      <= '0;
`endif
            stall_cnt_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);

            // Flush empties the stage but leaves the data fields stale.
            if (flush) begin
                state_q <= ST_EMPTY;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (push) begin
                            head_q  <= in_entry_d;
                            state_q <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (push && pop) begin
                            head_q <= in_entry_d;
`ifdef MEM_WB_SKID_EN
                        end else if (push) begin
                            skid_q  <= in_entry_d;
                            state_q <= ST_TWO;
`endif
                        end else if (pop) begin
                            state_q <= ST_EMPTY;
                        end
                    end
`ifdef MEM_WB_SKID_EN
                    ST_TWO: begin
                        if (pop) begin
                            head_q  <= skid_q;
                            state_q <= ST_ONE;
                        end
                    end
`endif
                    default: state_q <= ST_EMPTY;
                endcase
            end
        end
    end

    assign out_regwrite = out_valid && head_q.regwrite;
    assign out_memtoreg = head_q.memtoreg;
    assign out_writereg = head_q.writereg;
    assign out_wbdata   = head_q.wbdata;

    assign fwd_valid = out_regwrite && (head_q.writereg != '0);
    assign fwd_reg   = head_q.writereg;
    assign fwd_data  = head_q.wbdata;

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage_buf.sv
// Bench for mem_wb_stage_buf: directed vector table, hand-built corner sequences and random traffic
// checked against a queue-based model; a second instance with CNT_W=4 exercises counter saturation.
module tb_mem_wb_stage_buf;

`ifdef MEM_WB_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_regwrite, in_memtoreg, out_ready;
    logic [4:0]  in_writereg;
    logic [31:0] in_aluresult, in_readdata;

    logic        in_ready, out_valid, out_regwrite, out_memtoreg, fwd_valid;
    logic [4:0]  out_writereg, fwd_reg;
    logic [31:0] out_wbdata, fwd_data;
    logic [15:0] stall_cnt;

    logic        w4_in_ready, w4_out_valid, w4_out_regwrite, w4_out_memtoreg, w4_fwd_valid;
    logic [4:0]  w4_out_writereg, w4_fwd_reg;
    logic [31:0] w4_out_wbdata, w4_fwd_data;
    logic [3:0]  w4_stall_cnt;

    always #5 clk = ~clk;

    mem_wb_stage_buf dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_writereg(in_writereg),
        .in_aluresult(in_aluresult), .in_readdata(in_readdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_regwrite(out_regwrite), .out_memtoreg(out_memtoreg),
        .out_writereg(out_writereg), .out_wbdata(out_wbdata), .fwd_valid(fwd_valid),
        .fwd_reg(fwd_reg), .fwd_data(fwd_data), .stall_cnt(stall_cnt)
    );

    mem_wb_stage_buf #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(w4_in_ready),
        .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_writereg(in_writereg),
        .in_aluresult(in_aluresult), .in_readdata(in_readdata), .out_valid(w4_out_valid),
        .out_ready(out_ready), .out_regwrite(w4_out_regwrite), .out_memtoreg(w4_out_memtoreg),
        .out_writereg(w4_out_writereg), .out_wbdata(w4_out_wbdata), .fwd_valid(w4_fwd_valid),
        .fwd_reg(w4_fwd_reg), .fwd_data(w4_fwd_data), .stall_cnt(w4_stall_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit        rw;
        bit        m2r;
        bit [4:0]  wr;
        bit [31:0] wb;
    } ent_t;

    ent_t q[$];
    ent_t shown;
    int   cnt;
    bit   model_ok = 0;
    bit   last_push;

    function automatic bit m_in_ready();
        if (reset) return 1'b0;
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || out_ready;
    endfunction

    function automatic ent_t m_head();
        if (q.size() > 0) return q[0];
        return shown;
    endfunction

    task automatic model_compare();
        ent_t h;
        bit   ov, rw, fv;
        h  = m_head();
        ov = q.size() > 0;
        rw = ov && h.rw;
        fv = rw && (h.wr != 0);
        chk("in_ready", 64'(in_ready), 64'(m_in_ready()));
        chk("out_valid", 64'(out_valid), 64'(ov));
        chk("out_regwrite", 64'(out_regwrite), 64'(rw));
        chk("out_memtoreg", 64'(out_memtoreg), 64'(h.m2r));
        chk("out_writereg", 64'(out_writereg), 64'(h.wr));
        chk("out_wbdata", 64'(out_wbdata), 64'(h.wb));
        chk("fwd_valid", 64'(fwd_valid), 64'(fv));
        chk("fwd_reg", 64'(fwd_reg), 64'(h.wr));
        chk("fwd_data", 64'(fwd_data), 64'(h.wb));
        chk("stall_cnt", 64'(stall_cnt), 64'((cnt > 65535) ? 65535 : cnt));
        chk("stall_cnt4", 64'(w4_stall_cnt), 64'((cnt > 15) ? 15 : cnt));
        chk("w4_out_valid", 64'(w4_out_valid), 64'(ov));
        chk("w4_fwd_valid", 64'(w4_fwd_valid), 64'(fv));
        chk("w4_in_ready", 64'(w4_in_ready), 64'(m_in_ready()));
        chk("w4_wbdata", 64'({w4_out_regwrite, w4_out_memtoreg, w4_out_writereg, w4_fwd_reg,
                               w4_out_wbdata ^ w4_fwd_data}),
            64'({rw, h.m2r, h.wr, h.wr, 32'h0}));
    endtask

    task automatic model_step(input bit push, input bit pop);
        ent_t e;
        last_push = 0;
        if (reset) begin
            q.delete();
            shown    = '{0, 0, 0, 0};
            cnt      = 0;
            model_ok = 1;
        end else if (model_ok) begin
            if (q.size() > 0 && !out_ready) cnt++;
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) begin
                    e.rw  = in_regwrite;
                    e.m2r = in_memtoreg;
                    e.wr  = in_writereg;
                    e.wb  = in_memtoreg ? in_readdata : in_aluresult;
                    q.push_back(e);
                    last_push = 1;
                end
            end
            if (q.size() > 0) shown = q[0];
        end
    endtask

    task automatic cycle(input logic r, input logic f, input logic v, input logic rw,
                         input logic m2r, input logic [4:0] wr, input logic [31:0] alu,
                         input logic [31:0] rd, input logic ordy);
        bit push, pop;
        @(negedge clk);
        reset = r; flush = f; in_valid = v; in_regwrite = rw; in_memtoreg = m2r;
        in_writereg = wr; in_aluresult = alu; in_readdata = rd; out_ready = ordy;
        #1;
        if (model_ok) model_compare();
        push = v && m_in_ready();
        pop  = (q.size() > 0) && ordy;
        @(posedge clk);
        model_step(push, pop);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, fl, vld, rw, m2r;
        logic [4:0]  wr;
        logic [31:0] alu, rd;
        logic        ordy;
        logic        e_irdy, e_ov, e_rw, e_m2r;
        logic [4:0]  e_wr;
        logic [31:0] e_wb;
        logic        e_fv;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[6];
    int   idx;
    int   saved_cnt;

    initial begin
        reset = 1; flush = 0; in_valid = 0; in_regwrite = 0; in_memtoreg = 0;
        in_writereg = 0; in_aluresult = 0; in_readdata = 0; out_ready = 0;

        vecs[0] = '{1,0,0,0,0,0,32'h0,32'h0,1,         0,0,0,0,0,32'h0,0,16'd0};
        vecs[1] = '{0,0,1,1,1,3,32'h10,32'hDEADBEEF,1,  1,1,1,1,3,32'hDEADBEEF,1,16'd0};
        vecs[2] = '{0,0,1,1,0,0,32'h55,32'h99,1,        1,1,1,0,0,32'h55,0,16'd0};
        vecs[3] = '{0,0,1,1,0,7,32'h55,32'h77,1,        1,1,1,0,7,32'h55,1,16'd0};
        vecs[4] = '{0,0,1,0,1,9,32'h1,32'h1234,1,       1,1,0,1,9,32'h1234,0,16'd0};
        vecs[5] = '{0,0,0,0,0,0,32'h0,32'h0,1,          1,0,0,1,9,32'h1234,0,16'd0};

        for (int i = 0; i < 6; i++) begin
            cycle(vecs[i].rst, vecs[i].fl, vecs[i].vld, vecs[i].rw, vecs[i].m2r,
                  vecs[i].wr, vecs[i].alu, vecs[i].rd, vecs[i].ordy);
            #1;
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_irdy));
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            chk($sformatf("vec%0d_out_regwrite", i), 64'(out_regwrite), 64'(vecs[i].e_rw));
            chk($sformatf("vec%0d_out_memtoreg", i), 64'(out_memtoreg), 64'(vecs[i].e_m2r));
            chk($sformatf("vec%0d_out_writereg", i), 64'(out_writereg), 64'(vecs[i].e_wr));
            chk($sformatf("vec%0d_out_wbdata", i), 64'(out_wbdata), 64'(vecs[i].e_wb));
            chk($sformatf("vec%0d_fwd_valid", i), 64'(fwd_valid), 64'(vecs[i].e_fv));
            chk($sformatf("vec%0d_fwd_reg", i), 64'(fwd_reg), 64'(vecs[i].e_wr));
            chk($sformatf("vec%0d_fwd_data", i), 64'(fwd_data), 64'(vecs[i].e_wb));
            chk($sformatf("vec%0d_stall_cnt", i), 64'(stall_cnt), 64'(vecs[i].e_cnt));
        end

        // Skid build-up: three bundles offered while WB is stalled, then drained in order.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            cycle(0, 0, idx < 3, 1, 0, 5'(idx + 1), 32'h100 + 32'(idx), 32'h0, c >= 4);
            if (last_push) idx++;
            if (c == 3) begin
                #1;
                chk("skid_full_in_ready", 64'(in_ready), 64'(0));
                chk("skid_stall_cnt", 64'(stall_cnt), 64'(3));
            end
        end
        #1;
        chk("skid_all_accepted", 64'(idx), 64'(3));
        chk("skid_drained", 64'(out_valid), 64'(0));
        chk("skid_last_wbdata", 64'(out_wbdata), 64'(32'h102));

        // Flush while full, with a competing push and WB ready.
        cycle(0, 0, 1, 1, 0, 4, 32'hA0, 0, 0);
        cycle(0, 0, 1, 1, 0, 5, 32'hA1, 0, 0);
        #1;
        saved_cnt = int'(stall_cnt);
        cycle(0, 1, 1, 1, 0, 6, 32'hA2, 0, 1);
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_in_ready", 64'(in_ready), 64'(1));
        chk("flush_fwd_valid", 64'(fwd_valid), 64'(0));
        chk("flush_stall_cnt", 64'(stall_cnt), 64'(saved_cnt));
        for (int c = 0; c < 3; c++) begin
            cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
            #1;
            chk("flush_nothing_after", 64'(out_valid), 64'(0));
        end

        // Counter saturation, then reset in the middle of a stall.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 1, 12, 32'h1, 32'hCAFE, 0);
        for (int c = 0; c < 20; c++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("sat_cnt16", 64'(stall_cnt), 64'(20));
        chk("sat_cnt4", 64'(w4_stall_cnt), 64'(15));
        chk("sat_out_valid", 64'(out_valid), 64'(1));
        cycle(1, 1, 1, 1, 1, 3, 32'h3, 32'h4, 0);
        #1;
        chk("rst_mid_in_ready", 64'(in_ready), 64'(0));
        chk("rst_mid_outputs", 64'({out_valid, out_regwrite, out_memtoreg, out_writereg,
                                     out_wbdata, fwd_valid, fwd_reg}),
            64'(0));
        chk("rst_mid_fwd_data", 64'(fwd_data), 64'(0));
        chk("rst_mid_cnt", 64'({stall_cnt, w4_stall_cnt}), 64'(0));
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_release_in_ready", 64'(in_ready), 64'(1));

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            logic [4:0] wr;
            wr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            cycle($urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 2) != 0, 1'($urandom), 1'($urandom), wr,
                  $urandom, $urandom, $urandom_range(0, 9) < 6);
        end
        #1;
        if (model_ok) model_compare();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage_buf.md
# mem_wb_stage_buf

Parametrised, elastic MEM→WB pipeline stage for the pipelined MIPS core. It captures the memory-stage result bundle, pre-selects the writeback data, and presents it to WB under a valid/ready handshake with flush support. It also provides a forwarding tap and a saturating back-pressure counter. It replaces the fixed, always-advancing MEM/WB register wherever WB can stall.

## Interface
Parameters:
- DATA_W, 32, width of ALU result, read data and writeback data
- REG_ADDR_W, 5, width of destination register index
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  MEM offers a bundle
- in_ready  out  1  stage can accept this cycle
- in_regwrite  in  1  RegWrite control
- in_memtoreg  in  1  MemtoReg control
- in_writereg  in  REG_ADDR_W  destination register
- in_aluresult  in  DATA_W  ALU result
- in_readdata  in  DATA_W  data-memory read data
- out_valid  out  1  bundle presented to WB
- out_ready  in  1  WB consumes this cycle
- out_regwrite  out  1  RegWrite, forced 0 when out_valid=0
- out_memtoreg  out  1  MemtoReg of head entry
- out_writereg  out  REG_ADDR_W  destination of head entry
- out_wbdata  out  DATA_W  selected writeback data
- fwd_valid  out  1  out_valid & out_regwrite & (out_writereg != 0)
- fwd_reg  out  REG_ADDR_W  equals out_writereg
- fwd_data  out  DATA_W  equals out_wbdata
- stall_cnt  out  CNT_W  count of back-pressured cycles

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- wbdata = memtoreg ? readdata : aluresult. It is computed at capture and stored, so there is no output-side mux.
- Storage is a head (output) entry plus one skid entry.
- State machine:
  - EMPTY: push → ONE (head ← input).
  - ONE, push & !pop → TWO (skid ← input).
  - ONE, push & pop → ONE (head ← input).
  - ONE, pop & !push → EMPTY.
  - TWO, pop → ONE (head ← skid).
  - TWO, no pop → TWO. Push is impossible in TWO.
- in_ready = !reset & (state != TWO), derived from state only. There is no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Flush has priority over push and pop. Next state is EMPTY, and any same-cycle push is discarded. Data fields are not cleared.
- stall_cnt increments every cycle with out_valid & !out_ready. It saturates at all-ones, is cleared only by reset, and is unaffected by flush.
- Hazard unit must treat in_ready=0 as a MEM stall. Only the head entry is forwarded.

## Timing
- Latency: a bundle accepted at edge N is on the outputs with out_valid=1 after edge N. Throughput is 1 bundle per cycle while out_ready=1.
- Reset value of every output is 0: out_valid, out_regwrite, out_memtoreg, out_writereg, out_wbdata, fwd_*, and stall_cnt.
  - in_ready is 0 while reset is high and 1 the cycle after release.
- Reset mid-operation discards both entries at the next edge and returns to EMPTY.
- Flush and reset in the same cycle: reset wins, which also clears stall_cnt.
- Output fields are stable while out_valid & !out_ready; they change only on pop, push into EMPTY, or flush/reset.
- When out_valid=0, out_memtoreg, out_writereg and out_wbdata hold stale values. out_regwrite and fwd_valid are 0.

## Configuration
- MEM_WB_SKID_EN defined: two-entry skid behaviour as above. in_ready is state-only, giving full throughput under registered back-pressure.
- MEM_WB_SKID_EN undefined: head entry only, with states EMPTY/ONE.
  - in_ready = !reset & (!out_valid | out_ready), a combinational path from out_ready.
  - All other behaviour is identical: flush, counter, forwarding, reset.

## Test plan
- Reset then 4 back-to-back pushes, out_ready=1. Expect outputs one cycle after each push and in_ready constantly 1. Bundle (memtoreg=1, readdata=0xDEADBEEF, aluresult=0x10) gives out_wbdata=0xDEADBEEF.
- Push 3 bundles with out_ready=0 (skid build). Expect in_ready=0 after the 2nd push and the 3rd held upstream. Raising out_ready delivers all 3 in order; stall_cnt equals the number of stalled cycles.
- Flush asserted in state TWO together with in_valid=1. Expect out_valid=0 and in_ready=1 next cycle, nothing delivered afterward, and stall_cnt unchanged.
- Bundle regwrite=1, writereg=0, then regwrite=1, writereg=7, aluresult=0x55. Expect fwd_valid 0 then 1, with fwd_reg=7 and fwd_data=0x55.
- Set CNT_W=4 and hold out_ready=0 for 20 cycles with out_valid=1. Expect stall_cnt to stop at 15. Reset mid-stall clears all outputs to 0 at the next edge.
